// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES byte-substitution constants. Holds the 256-entry
//               FIPS-197 forward S-box and inverse S-box tables, and the
//               substitution direction encoding used on the mode inputs.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam logic MODE_FWD = 1'b0;   // SubBytes
    localparam logic MODE_INV = 1'b1;   // InvSubBytes

    localparam logic [7:0] SBOX_FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage
`default_nettype wire

// File: rtl/sbox_lane.sv
`default_nettype none
// ============================================================================
// Module      : sbox_lane
// Description : One combinational byte substitution through the forward or
//               inverse AES S-box table.
// Ports       : i_mode  - MODE_FWD / MODE_INV select
//               i_byte  - byte to substitute
//               o_byte  - substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_lane
    import aes_pkg::*;
(
    input  logic       i_mode,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = (i_mode == MODE_INV) ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];
    end

endmodule
`default_nettype wire

// File: rtl/sub_bytes_unit.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_unit
// Description : Multi-cycle AES (Inv)SubBytes engine. Captures an N_LANES-byte
//               state, substitutes SBOX_PER_CYCLE lanes per cycle in place and
//               presents the result with a valid/ready handshake.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid/in_ready     - input handshake
//               in_data, in_mode      - bytes to substitute, direction
//               out_valid/out_ready   - output handshake
//               out_data              - substituted bytes (same lane order)
//               busy                  - high while substituting
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_unit
    import aes_pkg::*;
#(
    parameter int N_LANES        = 16,
    parameter int SBOX_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*N_LANES-1:0] in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*N_LANES-1:0] out_data,
    output logic                 busy
);

    // Guarded copies keep the derived constants legal while the parameter
    // check below reports an illegal configuration.
    localparam int c_SPC    = (SBOX_PER_CYCLE < 1) ? 1 : SBOX_PER_CYCLE;
    localparam int c_BEATS  = (N_LANES / c_SPC < 1) ? 1 : N_LANES / c_SPC;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);

    generate
        if (N_LANES < 1 || SBOX_PER_CYCLE < 1 || (N_LANES % c_SPC) != 0) begin : g_bad_params
            $error("sub_bytes_unit: N_LANES=%0d must be >=1 and a multiple of SBOX_PER_CYCLE=%0d (>=1)",
                   N_LANES, SBOX_PER_CYCLE);
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [8*N_LANES-1:0]  r_data;
    logic                  r_mode;
    logic                  r_live;     // low until the first edge after reset release
    logic                  w_accept;
    logic [7:0]            w_lane_in  [c_SPC];
    logic [7:0]            w_lane_out [c_SPC];

    // The result register doubles as the working buffer: each beat reads the
    // captured bytes of its lane group and overwrites them with the result.
    generate
        for (genvar g = 0; g < c_SPC; g++) begin : g_sbox
            assign w_lane_in[g] = r_data[(int'(r_beat) * c_SPC + g) * 8 +: 8];

            sbox_lane u_sbox_lane (
                .i_mode (r_mode),
                .i_byte (w_lane_in[g]),
                .o_byte (w_lane_out[g])
            );
        end
    endgenerate

    assign in_ready  = r_live && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN);
    assign out_data  = r_data;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_beat == c_LAST_BEAT) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Output drains and a new input may enter on the same edge.
                if (out_ready) w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_data  <= '0;
            r_mode  <= MODE_FWD;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_data <= in_data;
                r_mode <= in_mode;
                r_beat <= '0;
            end else if (r_state == ST_RUN) begin
                for (int j = 0; j < c_SPC; j++) begin
                    r_data[(int'(r_beat) * c_SPC + j) * 8 +: 8] <= w_lane_out[j];
                end
                r_beat <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bytes_unit
// Description : Self-checking bench for sub_bytes_unit. Three instances with
//               SBOX_PER_CYCLE = 1, 4 (default) and 16. Expected bytes come
//               from an S-box computed by GF(2^8) inversion plus the affine
//               transform; expected results are queued at stimulus time and
//               popped when the unit presents its output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [2:0]        in_valid, in_mode, out_ready, in_ready, out_valid, busy;
    logic [2:0][127:0] in_data, out_data;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            sub_bytes_unit #(
                .N_LANES        (16),
                .SBOX_PER_CYCLE (g == 0 ? 1 : (g == 1 ? 4 : 16))
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_data   (in_data[g]),
                .in_mode   (in_mode[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    int           n_pass  = 0;
    int           n_fail  = 0;
    int           n_total = 0;
    logic [7:0]   mf [256];
    logic [7:0]   mi [256];
    logic [127:0] exp_q [$];

    // ---------------- reference S-box from field arithmetic ----------------
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_ref(logic [7:0] x);
        logic [7:0] inv;
        inv = '0;
        if (x != 0)
            for (int y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(logic [127:0] d, logic m);
        logic [127:0] r;
        for (int l = 0; l < 16; l++)
            r[8*l +: 8] = m ? mi[d[8*l +: 8]] : mf[d[8*l +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [127:0] obs, logic [127:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_valid(int u, output int lat);
        lat = 0;
        while (!out_valid[u] && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // One complete transaction: accept, check busy, scramble inputs after
    // acceptance, measure latency, compare against the queued expectation.
    task automatic run_txn(int u, logic [127:0] d, logic m, logic [127:0] expv,
                           int exp_lat, string tag, output logic [127:0] obs);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready[u] && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_rdy"}, 128'(in_ready[u]), 128'(1));
        in_valid[u]  = 1'b1;
        in_data[u]   = d;
        in_mode[u]   = m;
        out_ready[u] = 1'b1;
        exp_q.push_back(expv);
        tick();
        in_valid[u] = 1'b0;
        in_data[u]  = rnd128();
        in_mode[u]  = ~m;
        check({tag, "_busy"}, 128'(busy[u]), 128'(1));
        wait_valid(u, lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        obs = out_data[u];
        check({tag, "_data"}, obs, pop_exp());
        tick();
        check({tag, "_drain"}, 128'(out_valid[u]), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b, c, held, y, z;
        int           lat;

        for (int x = 0; x < 256; x++) mf[x] = sbox_ref(8'(x));
        for (int x = 0; x < 256; x++) mi[mf[x]] = 8'(x);

        rst_n     = 1'b0;
        in_valid  = '0;
        in_mode   = '0;
        out_ready = '1;
        in_data   = '0;
        tick();
        tick();

        // Reset state
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_in_ready%0d", u), 128'(in_ready[u]), 128'(0));
            check($sformatf("rst_busy%0d", u), 128'(busy[u]), 128'(0));
            check($sformatf("rst_out_valid%0d", u), 128'(out_valid[u]), 128'(0));
            check($sformatf("rst_out_data%0d", u), out_data[u], 128'(0));
        end
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 128'(in_ready[1]), 128'(1));

        // Known-answer vectors on the default instance
        run_txn(1, 128'(0), 1'b0, {16{8'h63}}, 4, "fwd_zero", y);
        run_txn(1, {16{8'h63}}, 1'b1, 128'(0), 4, "inv_63", y);
        run_txn(1, {{15{8'h63}}, 8'h00}, 1'b1, {120'(0), 8'h52}, 4, "inv_lane0_00", y);
        run_txn(1, {{15{8'h63}}, 8'hED}, 1'b1, {120'(0), 8'h53}, 4, "inv_lane0_ed", y);
        a = rnd128();
        run_txn(1, a, 1'b0, model(a, 1'b0), 4, "fwd_rand", y);
        a = rnd128();
        run_txn(1, a, 1'b1, model(a, 1'b1), 4, "inv_rand", y);

        // Back-to-back: second accept in the DONE cycle of the first
        a = rnd128();
        b = rnd128();
        in_valid[1] = 1'b1;
        in_data[1]  = a;
        in_mode[1]  = 1'b0;
        exp_q.push_back(model(a, 1'b0));
        tick();
        in_data[1] = b;
        exp_q.push_back(model(b, 1'b0));
        wait_valid(1, lat);
        check("b2b_lat_a", 128'(lat), 128'(4));
        check("b2b_rdy_in_done", 128'(in_ready[1]), 128'(1));
        check("b2b_data_a", out_data[1], pop_exp());
        tick();
        in_valid[1] = 1'b0;
        in_data[1]  = rnd128();
        check("b2b_no_bubble", 128'(busy[1]), 128'(1));
        wait_valid(1, lat);
        check("b2b_lat_b", 128'(lat), 128'(4));
        check("b2b_data_b", out_data[1], pop_exp());
        tick();

        // Downstream stall for 10 cycles in DONE
        c = rnd128();
        in_valid[1]  = 1'b1;
        in_data[1]   = c;
        in_mode[1]   = 1'b1;
        out_ready[1] = 1'b0;
        exp_q.push_back(model(c, 1'b1));
        tick();
        in_valid[1] = 1'b0;
        wait_valid(1, lat);
        check("stall_lat", 128'(lat), 128'(4));
        held = pop_exp();
        check("stall_data0", out_data[1], held);
        for (int i = 0; i < 10; i++) begin
            in_valid[1] = 1'b1;
            in_data[1]  = rnd128();
            in_mode[1]  = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("stall_valid%0d", i), 128'(out_valid[1]), 128'(1));
            check($sformatf("stall_data%0d", i), out_data[1], held);
            check($sformatf("stall_in_ready%0d", i), 128'(in_ready[1]), 128'(0));
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        tick();
        check("stall_release", 128'(out_valid[1]), 128'(0));

        // Reset asserted while beat 2 is pending
        a = rnd128();
        in_valid[1] = 1'b1;
        in_data[1]  = a;
        in_mode[1]  = 1'b0;
        exp_q.push_back(model(a, 1'b0));
        tick();
        in_valid[1] = 1'b0;
        tick();
        tick();
        check("mid_busy", 128'(busy[1]), 128'(1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 128'(out_valid[1]), 128'(0));
        check("mid_rst_data", out_data[1], 128'(0));
        check("mid_rst_busy", 128'(busy[1]), 128'(0));
        check("mid_rst_ready", 128'(in_ready[1]), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 128'(out_valid[1]), 128'(0));
        a = rnd128();
        run_txn(1, a, 1'b0, model(a, 1'b0), 4, "post_rst", y);

        // Sweep SBOX_PER_CYCLE: forward then inverse returns the input
        for (int u = 0; u < 3; u++) begin
            int el;
            el = (u == 0) ? 16 : ((u == 1) ? 4 : 1);
            a = rnd128();
            run_txn(u, a, 1'b0, model(a, 1'b0), el, $sformatf("sweep%0d_fwd", u), y);
            run_txn(u, y, 1'b1, a, el, $sformatf("sweep%0d_inv", u), z);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
